reg_share_arbiter: RTL and testbench
====================================

Name: reg_share_arbiter

Overview:
Round-robin write arbiter that shares one data_t storage register between NUM_REQ requesters.
- Each requester presents req plus wdata; the winner's data is captured into the shared register.
- A one-cycle grant/valid pulse is issued, then the register is held for HOLD_CYCLES before re-arbitration.
- Sits in front of the datapath register stage, replacing its free-running d input with arbitrated, enable-gated loads.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
HOLD_CYCLES, 2, cycles the register is held (busy) after each grant, including the grant cycle (>=1)
(data width is DATA_WIDTH / data_t from soc_pkg, not a local parameter)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  reset, asynchronous, active-low
req  input  NUM_REQ  per-requester write request, level
wdata  input  NUM_REQ*DATA_WIDTH  packed write data; slice i = requester i
gnt  output  NUM_REQ  one-hot grant pulse, registered
q  output  DATA_WIDTH (data_t)  shared register contents
q_valid  output  1  pulse: q updated this cycle
owner  output  max(1,$clog2(NUM_REQ))  index of last granted requester
busy  output  1  high while in HOLD

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately, including mid-HOLD):
  - q=0, q_valid=0, gnt=0, owner=0, busy=0.
  - state=IDLE, rr pointer ptr=0, hold counter cnt=0.
- States: IDLE, HOLD.
- IDLE, at a rising edge with |req:
  - Winner = first set req bit searching ptr, ptr+1, ... mod NUM_REQ.
  - Edge updates: q<=wdata[winner]; gnt<=onehot(winner); q_valid<=1; owner<=winner.
  - ptr<=(winner+1) mod NUM_REQ; cnt<=1; state<=HOLD.
- IDLE, no req: outputs hold except gnt=0 and q_valid=0; ptr unchanged.
- HOLD, at each edge:
  - gnt<=0, q_valid<=0; req is ignored.
  - If cnt==HOLD_CYCLES then state<=IDLE, else cnt<=cnt+1.
- busy = (state==HOLD), registered.
- Latency: req sampled at edge t → gnt/q/q_valid/owner visible in the cycle after edge t.
- Grant spacing: minimum spacing between successive grants is HOLD_CYCLES+1 edges.
- Requester handshake:
  - Hold req and wdata stable until gnt is seen.
  - Deassert req in the gnt cycle or during HOLD if no further write is wanted.
  - req still high when the arbiter returns to IDLE counts as a new request.
- Request withdrawn before being granted: no effect, no grant.
- Fairness: a continuously asserted req is granted within NUM_REQ grants.
- NUM_REQ=1: ptr is always 0; owner is always 0.
- q holds its value indefinitely between grants; there are no partial writes.

Test Plan (NUM_REQ=4, HOLD_CYCLES=2, DATA_WIDTH=8):
1. Reset: drive rst_n=0 mid-cycle with random inputs → outputs go to 0 immediately, without waiting for clk; all stay 0 while rst_n=0.
2. Single write: req=4'b0010, wdata[1]=8'hA5 sampled at edge t.
   - Cycle after t: gnt=4'b0010, q=8'hA5, q_valid=1, owner=1, busy=1.
   - Next cycle: gnt=0, q_valid=0, busy=1, q=8'hA5.
   - Following cycle: busy=0.
3. All requesters held high from reset, wdata[i]=8'h10+i → grants 0,1,2,3,0 at 3-cycle spacing; q sequence 10,11,12,13,10.
4. Pointer rotation: after a grant to requester 2, req=4'b1010 → next grant 3 (q=wdata[3]), then grant 1.
5. Withdrawal: req=4'b0001 pulsed during HOLD only, deasserted before IDLE → no grant; q keeps its old value and q_valid stays 0.
6. Reset mid-HOLD: rst_n low in the cycle after a grant → q=0 and busy=0 immediately. After release, req=4'b1001 → grant 0 (ptr reset to 0).

Source files
------------

// File: rtl/soc_pkg.sv
// Shared SoC datapath types.
package soc_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/reg_share_arbiter.sv
// Round-robin write arbiter in front of one shared data_t register.
// A grant loads the winner's wdata, pulses gnt/q_valid, then holds the
// register for HOLD_CYCLES cycles (grant cycle included) before re-arbitrating.
module reg_share_arbiter
  import soc_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]          wdata,
  output logic [NUM_REQ-1:0]                     gnt,
  output data_t                                  q,
  output logic                                   q_valid,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] owner,
  output logic                                   busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   gnt_d;
  data_t                q_d;
  logic                 q_valid_d;
  logic [PTR_W-1:0]     owner_d;
  logic                 busy_d;
  logic [PTR_W-1:0]     idx;
  logic [PTR_W-1:0]     win;
  logic                 found;

  // State, pointer, counter and all outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      owner   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      q       <= q_d;
      q_valid <= q_valid_d;
      owner   <= owner_d;
      busy    <= busy_d;
    end
  end

  // Round-robin winner search starting at ptr, then next-state and output values.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    q_d       = q;
    q_valid_d = 1'b0;
    owner_d   = owner;
    idx       = '0;
    win       = '0;
    found     = 1'b0;

    for (int i = 0; i < int'(NUM_REQ); i++) begin
      idx = PTR_W'((int'(ptr_q) + i) % int'(NUM_REQ));
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (found) begin
          q_d        = wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          gnt_d[win] = 1'b1;
          q_valid_d  = 1'b1;
          owner_d    = win;
          ptr_d      = PTR_W'((int'(win) + 1) % int'(NUM_REQ));
          cnt_d      = CNT_W'(1);
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == HOLD);
  end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter (NUM_REQ=4, HOLD_CYCLES=2, 8-bit data).
module tb_reg_share_arbiter;
  import soc_pkg::*;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned HOLD_CYCLES = 2;

  typedef struct packed {
    logic [NUM_REQ-1:0] gnt;
    data_t              q;
    logic [1:0]         owner;
  } exp_t;

  logic                          clk;
  logic                          rst_n;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]            gnt;
  data_t                         q;
  logic                          q_valid;
  logic [1:0]                    owner;
  logic                          busy;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  reg_share_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid),
    .owner   (owner),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_wd(input int i, input data_t v);
    wdata[i*DATA_WIDTH +: DATA_WIDTH] = v;
  endtask

  task automatic push(input logic [NUM_REQ-1:0] g, input data_t d, input logic [1:0] o);
    exp_t e;
    e.gnt   = g;
    e.q     = d;
    e.owner = o;
    exp_q.push_back(e);
  endtask

  // Monitor: every q_valid pulse must match the oldest expected grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant gnt", 32'(gnt), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_gnt", 32'(gnt), 32'(e.gnt));
          chk("sb_q", 32'(q), 32'(e.q));
          chk("sb_owner", 32'(owner), 32'(e.owner));
          chk("sb_busy", 32'(busy), 32'h1);
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_q"}, 32'(q), 32'h0);
    chk({tag, "_gnt"}, 32'(gnt), 32'h0);
    chk({tag, "_q_valid"}, 32'(q_valid), 32'h0);
    chk({tag, "_owner"}, 32'(owner), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    wdata = '0;
    step(2);
    chk_zero("reset_init");
    rst_n = 1'b1;
    step(1);

    // Single write from requester 1
    set_wd(1, 8'hA5);
    req = 4'b0010;
    push(4'b0010, 8'hA5, 2'd1);
    step(1);
    chk("single_busy0", 32'(busy), 32'h1);
    req = '0;
    step(1);
    chk("single_gnt1", 32'(gnt), 32'h0);
    chk("single_qv1", 32'(q_valid), 32'h0);
    chk("single_busy1", 32'(busy), 32'h1);
    chk("single_q1", 32'(q), 32'hA5);
    step(1);
    chk("single_busy2", 32'(busy), 32'h0);
    chk("single_q2", 32'(q), 32'hA5);

    // Asynchronous reset mid-cycle with random inputs
    #2;
    req   = 4'($urandom);
    wdata = 32'($urandom);
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    chk_zero("rst_held");

    // All requesters high from reset: grants 0,1,2,3,0 every 3 edges
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_wd(i, data_t'(8'h10 + i));
    req = 4'b1111;
    push(4'b0001, 8'h10, 2'd0);
    push(4'b0010, 8'h11, 2'd1);
    push(4'b0100, 8'h12, 2'd2);
    push(4'b1000, 8'h13, 2'd3);
    push(4'b0001, 8'h10, 2'd0);
    rst_n = 1'b1;
    step(14);
    req = '0;
    step(4);
    chk("all_req_drained", 32'(exp_q.size()), 32'h0);

    // Pointer rotation: grant 2, then req 1010 gives 3 then 1
    set_wd(2, 8'h22);
    set_wd(3, 8'h33);
    set_wd(1, 8'h31);
    req = 4'b0100;
    push(4'b0100, 8'h22, 2'd2);
    push(4'b1000, 8'h33, 2'd3);
    push(4'b0010, 8'h31, 2'd1);
    step(1);
    req = 4'b1010;
    step(6);
    req = '0;
    step(4);
    chk("rotate_drained", 32'(exp_q.size()), 32'h0);

    // Withdrawal: req pulsed only during HOLD is never granted
    set_wd(2, 8'h44);
    set_wd(0, 8'hEE);
    req = 4'b0100;
    push(4'b0100, 8'h44, 2'd2);
    step(1);
    req = 4'b0001;
    step(1);
    chk("withdraw_qv_hold", 32'(q_valid), 32'h0);
    req = '0;
    step(1);
    chk("withdraw_busy_end", 32'(busy), 32'h0);
    step(3);
    chk("withdraw_q", 32'(q), 32'h44);
    chk("withdraw_qv", 32'(q_valid), 32'h0);
    chk("withdraw_drained", 32'(exp_q.size()), 32'h0);

    // Reset in the cycle after a grant, then pointer restarts at 0
    set_wd(1, 8'h55);
    req = 4'b0010;
    push(4'b0010, 8'h55, 2'd1);
    step(1);
    req = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midhold_rst_q", 32'(q), 32'h0);
    chk("midhold_rst_busy", 32'(busy), 32'h0);
    chk("midhold_rst_gnt", 32'(gnt), 32'h0);
    step(1);
    set_wd(0, 8'h66);
    set_wd(3, 8'h77);
    req = 4'b1001;
    push(4'b0001, 8'h66, 2'd0);
    rst_n = 1'b1;
    step(1);
    req = '0;
    step(4);
    chk("final_drained", 32'(exp_q.size()), 32'h0);
    chk("final_q", 32'(q), 32'h66);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
